mem_access_ctrl: RTL and testbench

- M-stage data-memory access controller. Sits directly downstream of the datapath.
- Consumes aluoutM (address), writedataM and the M-stage memory controls.
- Drives an SRAM-like data bus (req / addr_ok / data_ok).
- Returns aligned, sign- or zero-extended load data (mem_ctrl_rdataM) and a pipeline stall.
- Performs address-alignment checks and reports AdEL/AdES to the exception logic.

---
 rtl/mem_access_ctrl_if.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data-memory bus between the M-stage access controller (master)
// and the memory port (slave): request/address phase plus data/ack phase.
interface mem_access_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [3:0]    data_wstrb;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    output data_wstrb,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    input  data_wstrb,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: alignment checks, store lane steering,
// one outstanding bus transaction at a time, load extraction/extension and stall.
module mem_access_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_readM,
  input  logic          mem_writeM,
  input  logic [1:0]    mem_sizeM,
  input  logic          mem_unsignedM,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  input  logic          flush_exceptionM,
  input  logic          pipe_stall_other,
  mem_access_ctrl_if.master bus,
  output logic [DW-1:0] mem_ctrl_rdataM,
  output logic          mem_stallM,
  output logic          addrErrorLwM,
  output logic          addrErrorSwM,
  output logic [AW-1:0] badvaddrM
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  function automatic logic [DW-1:0] store_lanes(input logic [1:0] size, input logic [DW-1:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] rd, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   return uns ? DW'($unsigned(b)) : DW'(b);
      2'b01:   return uns ? DW'($unsigned(h)) : DW'(h);
      default: return rd;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          cancel_q, cancel_d;
  logic          req_q, req_d;
  logic          wr_q, wr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic addr_err;
  logic access_valid;
  logic cancel_eff;

  assign addr_err = ((mem_sizeM == 2'b01) & aluoutM[0]) |
                    (mem_sizeM[1] & (aluoutM[1:0] != 2'b00));
  assign addrErrorLwM = mem_readM & addr_err;
  assign addrErrorSwM = mem_writeM & addr_err;
  assign badvaddrM    = addr_err ? aluoutM : '0;
  assign access_valid = (mem_readM | mem_writeM) & ~addr_err & ~flush_exceptionM;
  // A flush in the current cycle already releases the stall for the flushed instruction.
  assign cancel_eff   = cancel_q | flush_exceptionM;

  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    req_d      = req_q;
    wr_d       = wr_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_stallM = 1'b0;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (access_valid) begin
          state_d    = REQ;
          req_d      = 1'b1;
          wr_d       = mem_writeM;
          size_d     = mem_sizeM[1] ? 2'b10 : mem_sizeM;
          uns_d      = mem_unsignedM;
          addr_d     = aluoutM;
          wdata_d    = store_lanes(mem_sizeM, writedataM);
          wstrb_d    = mem_writeM ? store_strb(mem_sizeM, aluoutM[1:0]) : 4'b0000;
          mem_stallM = 1'b1;
        end
      end
      REQ: begin
        if (flush_exceptionM) cancel_d = 1'b1;
        mem_stallM = cancel_eff ? access_valid : 1'b1;
        // data_ok here is a protocol violation and deliberately not looked at.
        if (bus.data_addr_ok) begin
          state_d = DATA;
          req_d   = 1'b0;
        end
      end
      DATA: begin
        if (flush_exceptionM) cancel_d = 1'b1;
        mem_stallM = cancel_eff ? access_valid : 1'b1;
        if (bus.data_data_ok) begin
          if (cancel_eff) begin
            state_d  = IDLE;
            cancel_d = 1'b0;
          end else begin
            state_d = DONE;
            if (!wr_q) rdata_d = load_extract(bus.data_rdata, addr_q[1:0], size_q, uns_q);
          end
        end
      end
      DONE: begin
        if (!pipe_stall_other || flush_exceptionM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered bus/result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      wstrb_q  <= 4'b0000;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
    end
  end

  // Latched access fields; only meaningful while req/wstrb qualify them.
  always_ff @(posedge clk) begin
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.data_req   = req_q;
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign bus.data_wstrb = wstrb_q;
  assign mem_ctrl_rdataM = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, flush/reset sequences and
// randomized accesses against an arithmetic reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_readM, mem_writeM, mem_unsignedM, flush_exceptionM, pipe_stall_other;
  logic [1:0]  mem_sizeM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] mem_ctrl_rdataM, badvaddrM;
  logic        mem_stallM, addrErrorLwM, addrErrorSwM;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.AW(32), .DW(32)) bus ();

  mem_access_ctrl #(.AW(32), .DW(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_readM        (mem_readM),
    .mem_writeM       (mem_writeM),
    .mem_sizeM        (mem_sizeM),
    .mem_unsignedM    (mem_unsignedM),
    .aluoutM          (aluoutM),
    .writedataM       (writedataM),
    .flush_exceptionM (flush_exceptionM),
    .pipe_stall_other (pipe_stall_other),
    .bus              (bus),
    .mem_ctrl_rdataM  (mem_ctrl_rdataM),
    .mem_stallM       (mem_stallM),
    .addrErrorLwM     (addrErrorLwM),
    .addrErrorSwM     (addrErrorSwM),
    .badvaddrM        (badvaddrM)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wd, resp;
    int          adly, ddly, hold;
    logic        el, es;
    logic [1:0]  esz;
    logic [3:0]  estrb;
    logic [31:0] ewd, erd;
  } vec_t;

  vec_t        tbl[15];
  logic [31:0] r_addr;
  logic [1:0]  r_sz;
  int          r_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic rd, wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, wd, resp, input int adly, ddly, hold,
                              input logic el, es, input logic [1:0] esz, input logic [3:0] estrb,
                              input logic [31:0] ewd, erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.resp = resp;
    v.adly = adly; v.ddly = ddly; v.hold = hold;
    v.el = el; v.es = es; v.esz = esz; v.estrb = estrb; v.ewd = ewd; v.erd = erd;
    return v;
  endfunction

  // Reference: bytes of the access, offset in the word, shift/mask/replicate arithmetic.
  function automatic vec_t model(input logic rd, wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, wd, resp, input int adly, ddly, hold);
    vec_t v;
    int nb, off;
    longint unsigned lim, field;
    logic mis;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    mis = (addr % nb) != 0;
    lim = 64'd1 << (8 * nb);
    field = (64'(resp) >> (8 * off)) % lim;
    if (!uns && nb < 4 && field >= lim / 2) field = field + 64'h1_0000_0000 - lim;
    v = mk(rd, wr, sz, uns, addr, wd, resp, adly, ddly, hold,
           rd && mis, wr && mis,
           (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2,
           wr ? 4'(((1 << nb) - 1) << off) : 4'd0,
           (nb == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
           (nb == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd,
           32'(field));
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    mem_readM = v.rd; mem_writeM = v.wr; mem_sizeM = v.sz; mem_unsignedM = v.uns;
    aluoutM = v.addr; writedataM = v.wd; flush_exceptionM = 1'b0; pipe_stall_other = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    smp();
    chk({nm, " errL"}, 32'(addrErrorLwM), 32'(v.el));
    chk({nm, " errS"}, 32'(addrErrorSwM), 32'(v.es));
    if (!v.rd && !v.wr) begin
      chk({nm, " idle stall"}, 32'(mem_stallM), 32'd0);
      chk({nm, " idle req"}, 32'(bus.data_req), 32'd0);
      adv();
      return;
    end
    if (v.el || v.es) begin
      chk({nm, " badvaddr"}, badvaddrM, v.addr);
      chk({nm, " err stall"}, 32'(mem_stallM), 32'd0);
      adv();
      smp();
      chk({nm, " err no req"}, 32'(bus.data_req), 32'd0);
      adv();
      mem_readM = 1'b0; mem_writeM = 1'b0;
      return;
    end
    chk({nm, " badvaddr"}, badvaddrM, 32'd0);
    chk({nm, " c0 stall"}, 32'(mem_stallM), 32'd1);
    adv();
    for (int i = 0; i <= v.adly; i++) begin
      bus.data_addr_ok = (i == v.adly);
      bus.data_data_ok = 1'($urandom_range(0, 1));
      bus.data_rdata = $urandom;
      smp();
      chk({nm, " req"}, 32'(bus.data_req), 32'd1);
      chk({nm, " addr"}, bus.data_addr, v.addr);
      chk({nm, " wr"}, 32'(bus.data_wr), 32'(v.wr));
      chk({nm, " size"}, 32'(bus.data_size), 32'(v.esz));
      chk({nm, " wstrb"}, 32'(bus.data_wstrb), 32'(v.estrb));
      if (v.wr) chk({nm, " wdata"}, bus.data_wdata, v.ewd);
      chk({nm, " req stall"}, 32'(mem_stallM), 32'd1);
      adv();
    end
    bus.data_addr_ok = 1'b0;
    for (int j = 0; j <= v.ddly; j++) begin
      bus.data_data_ok = (j == v.ddly);
      bus.data_rdata = (j == v.ddly) ? v.resp : $urandom;
      smp();
      chk({nm, " data req"}, 32'(bus.data_req), 32'd0);
      chk({nm, " data stall"}, 32'(mem_stallM), 32'd1);
      adv();
    end
    bus.data_data_ok = 1'b0;
    for (int k = 0; k <= v.hold; k++) begin
      pipe_stall_other = (k < v.hold);
      smp();
      chk({nm, " done stall"}, 32'(mem_stallM), 32'd0);
      chk({nm, " done req"}, 32'(bus.data_req), 32'd0);
      if (v.rd) chk({nm, " rdata"}, mem_ctrl_rdataM, v.erd);
      adv();
    end
    pipe_stall_other = 1'b0; mem_readM = 1'b0; mem_writeM = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_readM = 0; mem_writeM = 0; mem_sizeM = 0; mem_unsignedM = 0;
    aluoutM = 0; writedataM = 0; flush_exceptionM = 0; pipe_stall_other = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;

    //        rd wr sz    u  addr           wd             resp          ad dd h  eL eS esz   strb     ewd            erd
    tbl[0]  = mk(1, 0, 2'd2, 0, 32'h8000_0010, 32'h0,         32'h1234_5678, 0, 0, 0, 0, 0, 2'd2, 4'b0000, 32'h0,         32'h1234_5678);
    tbl[1]  = mk(1, 0, 2'd0, 0, 32'h8000_0013, 32'h0,         32'h80FF_7F01, 0, 0, 0, 0, 0, 2'd0, 4'b0000, 32'h0,         32'hFFFF_FF80);
    tbl[2]  = mk(1, 0, 2'd0, 1, 32'h8000_0013, 32'h0,         32'h80FF_7F01, 1, 0, 0, 0, 0, 2'd0, 4'b0000, 32'h0,         32'h0000_0080);
    tbl[3]  = mk(1, 0, 2'd1, 0, 32'h8000_0002, 32'h0,         32'h80FF_7F01, 0, 1, 0, 0, 0, 2'd1, 4'b0000, 32'h0,         32'hFFFF_80FF);
    tbl[4]  = mk(0, 1, 2'd1, 0, 32'h8000_0006, 32'h0000_BEEF, 32'h0,         0, 0, 0, 0, 0, 2'd1, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    tbl[5]  = mk(0, 1, 2'd0, 0, 32'h8000_0001, 32'h0000_00AB, 32'h0,         2, 0, 0, 0, 0, 2'd0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    tbl[6]  = mk(1, 0, 2'd2, 0, 32'h8000_0002, 32'h0,         32'h0,         0, 0, 0, 1, 0, 2'd2, 4'b0000, 32'h0,         32'h0);
    tbl[7]  = mk(0, 1, 2'd2, 0, 32'h8000_0001, 32'h1111_2222, 32'h0,         0, 0, 0, 0, 1, 2'd2, 4'b0000, 32'h0,         32'h0);
    tbl[8]  = mk(1, 0, 2'd2, 0, 32'h8000_0020, 32'h0,         32'hCAFE_F00D, 1, 1, 2, 0, 0, 2'd2, 4'b0000, 32'h0,         32'hCAFE_F00D);
    tbl[9]  = mk(1, 0, 2'd1, 1, 32'h8000_0004, 32'h0,         32'h1234_9ABC, 0, 0, 0, 0, 0, 2'd1, 4'b0000, 32'h0,         32'h0000_9ABC);
    tbl[10] = mk(0, 1, 2'd2, 0, 32'h8000_0008, 32'h0102_0304, 32'h0,         0, 2, 1, 0, 0, 2'd2, 4'b1111, 32'h0102_0304, 32'h0);
    tbl[11] = mk(1, 0, 2'd3, 0, 32'h8000_000C, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'd2, 4'b0000, 32'h0,         32'hDEAD_BEEF);
    tbl[12] = mk(1, 0, 2'd1, 0, 32'h8000_0003, 32'h0,         32'h0,         0, 0, 0, 1, 0, 2'd1, 4'b0000, 32'h0,         32'h0);
    tbl[13] = mk(0, 1, 2'd0, 0, 32'h8000_0003, 32'h0000_005A, 32'h0,         0, 0, 0, 0, 0, 2'd0, 4'b1000, 32'h5A5A_5A5A, 32'h0);
    tbl[14] = mk(1, 0, 2'd0, 0, 32'h8000_0011, 32'h0,         32'h0000_7F00, 0, 0, 0, 0, 0, 2'd0, 4'b0000, 32'h0,         32'h0000_007F);

    adv(); adv();
    smp();
    chk("reset req", 32'(bus.data_req), 32'd0);
    chk("reset wr", 32'(bus.data_wr), 32'd0);
    chk("reset wstrb", 32'(bus.data_wstrb), 32'd0);
    chk("reset rdata", mem_ctrl_rdataM, 32'd0);
    chk("reset stall", 32'(mem_stallM), 32'd0);
    adv();
    rst = 1'b1;

    for (int t = 0; t < 15; t++) run_txn(tbl[t], $sformatf("vec%0d", t));

    // Reset while a store is in its data phase.
    mem_writeM = 1; mem_sizeM = 2'd2; aluoutM = 32'h8000_0010; writedataM = 32'h1122_3344;
    smp(); chk("rstdata c0 stall", 32'(mem_stallM), 32'd1); adv();
    bus.data_addr_ok = 1;
    smp(); chk("rstdata req", 32'(bus.data_req), 32'd1); chk("rstdata wr", 32'(bus.data_wr), 32'd1); adv();
    bus.data_addr_ok = 0; rst = 1'b0;
    smp(); chk("rstdata data req", 32'(bus.data_req), 32'd0); adv();
    rst = 1'b1; mem_writeM = 0;
    smp();
    chk("rstdata after req", 32'(bus.data_req), 32'd0);
    chk("rstdata after wr", 32'(bus.data_wr), 32'd0);
    chk("rstdata after wstrb", 32'(bus.data_wstrb), 32'd0);
    chk("rstdata after rdata", mem_ctrl_rdataM, 32'd0);
    chk("rstdata after stall", 32'(mem_stallM), 32'd0);
    adv();
    smp(); chk("rstdata idle req", 32'(bus.data_req), 32'd0); adv();

    // Flush in REQ with addr_ok three cycles late, new load queued behind it.
    mem_readM = 1; mem_sizeM = 2'd2; mem_unsignedM = 0; aluoutM = 32'h8000_0040;
    smp(); chk("flq c0 stall", 32'(mem_stallM), 32'd1); adv();
    flush_exceptionM = 1;
    smp(); chk("flq c1 req", 32'(bus.data_req), 32'd1); chk("flq c1 stall", 32'(mem_stallM), 32'd0); adv();
    flush_exceptionM = 0; mem_readM = 0;
    smp(); chk("flq c2 req", 32'(bus.data_req), 32'd1); chk("flq c2 stall", 32'(mem_stallM), 32'd0); adv();
    mem_readM = 1; aluoutM = 32'h8000_0044; bus.data_data_ok = 1;
    smp(); chk("flq c3 req", 32'(bus.data_req), 32'd1); chk("flq c3 stall", 32'(mem_stallM), 32'd1);
    chk("flq c3 addr", bus.data_addr, 32'h8000_0040); adv();
    bus.data_data_ok = 0; bus.data_addr_ok = 1;
    smp(); chk("flq c4 req", 32'(bus.data_req), 32'd1); chk("flq c4 addr", bus.data_addr, 32'h8000_0040); adv();
    bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'hFFFF_0000;
    smp(); chk("flq c5 req", 32'(bus.data_req), 32'd0); chk("flq c5 stall", 32'(mem_stallM), 32'd1); adv();
    bus.data_data_ok = 0;
    smp(); chk("flq c6 req", 32'(bus.data_req), 32'd0); chk("flq c6 stall", 32'(mem_stallM), 32'd1);
    chk("flq c6 discarded", mem_ctrl_rdataM, 32'd0); adv();
    bus.data_addr_ok = 1;
    smp(); chk("flq c7 req", 32'(bus.data_req), 32'd1); chk("flq c7 addr", bus.data_addr, 32'h8000_0044); adv();
    bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h5566_7788;
    smp(); chk("flq c8 stall", 32'(mem_stallM), 32'd1); adv();
    bus.data_data_ok = 0;
    smp(); chk("flq c9 stall", 32'(mem_stallM), 32'd0); chk("flq c9 rdata", mem_ctrl_rdataM, 32'h5566_7788); adv();
    mem_readM = 0;

    // Flush in DATA: data_ok still awaited, then back to IDLE with result untouched.
    mem_readM = 1; aluoutM = 32'h8000_0048;
    smp(); chk("fld c0 stall", 32'(mem_stallM), 32'd1); adv();
    bus.data_addr_ok = 1;
    smp(); chk("fld c1 req", 32'(bus.data_req), 32'd1); adv();
    bus.data_addr_ok = 0; flush_exceptionM = 1;
    smp(); chk("fld c2 stall", 32'(mem_stallM), 32'd0); adv();
    flush_exceptionM = 0; mem_readM = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h0BAD_0BAD;
    smp(); chk("fld c3 stall", 32'(mem_stallM), 32'd0); chk("fld c3 req", 32'(bus.data_req), 32'd0); adv();
    bus.data_data_ok = 0;
    smp(); chk("fld c4 rdata", mem_ctrl_rdataM, 32'h5566_7788); chk("fld c4 stall", 32'(mem_stallM), 32'd0); adv();
    run_txn(model(1, 0, 2'd0, 0, 32'h8000_004D, 32'h0, 32'h00C3_0000, 0, 0, 0), "fld next");

    for (int n = 0; n < 40; n++) begin
      r_op = $urandom_range(0, 5);
      r_sz = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
      run_txn(model(r_op >= 1 && r_op <= 3, r_op >= 4, r_sz, 1'($urandom_range(0, 1)), r_addr,
                    $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
